// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response channel plus
// the valid/stall handshake and redirect inputs from the decode stage.
// The master modport is the fetch unit; the slave modport is its environment
// (memory model and decode stage together).
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  // Instruction-memory channel
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  // Control inputs from decode
  logic              stall;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;

  // Instruction stream toward decode
  logic [DATA_W-1:0] instr;
  logic              instr_valid;
  logic [ADDR_W-1:0] instr_pc;
  logic [ADDR_W-1:0] instr_pc_plus2;
  logic              halted;

  modport master (
    output mem_req, mem_addr,
    input  mem_ack, mem_rdata,
    input  stall, redirect, redirect_pc,
    output instr, instr_valid, instr_pc, instr_pc_plus2, halted
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_ack, mem_rdata,
    output stall, redirect, redirect_pc,
    input  instr, instr_valid, instr_pc, instr_pc_plus2, halted
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, keeps at most one read outstanding to a
// variable-latency instruction memory, and buffers one instruction toward
// decode with a valid/stall handshake. Redirects (taken branches) refetch from
// redirect_pc; an in-flight read overtaken by a redirect is killed so its data
// is dropped. Fetch stops after an HLT (opcode 4'hF) until the next redirect.
//
// Optional feature macro FETCH_PERF_CNT_EN: when defined, adds the saturating
// perf_wait_cycles and perf_kill_count outputs.
module instr_fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  instr_fetch_unit_if.master bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]        perf_wait_cycles,
  output logic [15:0]        perf_kill_count
`endif
);

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_WAIT   = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam logic [3:0] OPC_HLT = 4'hF;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic              r_kill;
  logic [DATA_W-1:0] r_instr;
  logic [ADDR_W-1:0] r_instr_pc;
  logic              r_instr_valid;
  logic              r_halted;

  logic              w_can_issue;
  logic              w_consume;
  logic              w_ack_accept;
  logic              w_ack_discard;
  logic              w_is_hlt;
  logic [ADDR_W-1:0] w_pc_plus2;

  // A new fetch may start when the buffer is empty or is drained this cycle;
  // with a single outstanding read this guarantees the ack finds room.
  assign w_can_issue   = !r_instr_valid || !bus.stall;
  assign w_consume     = r_instr_valid && !bus.stall;
  assign w_ack_accept  = (r_state == ST_WAIT) && bus.mem_ack && !bus.redirect && !r_kill;
  assign w_ack_discard = (r_state == ST_WAIT) && bus.mem_ack && (bus.redirect || r_kill);
  assign w_is_hlt      = (bus.mem_rdata[DATA_W-1 -: 4] == OPC_HLT);
  assign w_pc_plus2    = r_pc + ADDR_W'(2);

  assign bus.mem_req        = (r_state == ST_FETCH) && w_can_issue && !bus.redirect;
  assign bus.mem_addr       = r_pc;
  assign bus.instr          = r_instr;
  assign bus.instr_valid    = r_instr_valid;
  assign bus.instr_pc       = r_instr_pc;
  assign bus.instr_pc_plus2 = r_instr_pc + ADDR_W'(2);
  assign bus.halted         = r_halted;

  // Fetch FSM together with the PC, kill flag and the one-entry output buffer.
  // NOTE: all state here uses non-blocking assignments and a synchronous reset
  // tested first, so every register sees pre-edge values and reset wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_FETCH;
      r_pc          <= RESET_PC;
      r_kill        <= 1'b0;
      r_instr       <= '0;
      r_instr_pc    <= '0;
      r_instr_valid <= 1'b0;
      r_halted      <= 1'b0;
    end else begin
      // Output buffer: a redirect flushes it ahead of both load and hold.
      if (bus.redirect) begin
        r_instr_valid <= 1'b0;
      end else if (w_ack_accept) begin
        r_instr_valid <= 1'b1;
        r_instr       <= bus.mem_rdata;
        r_instr_pc    <= r_pc;
      end else if (w_consume) begin
        r_instr_valid <= 1'b0;
      end

      case (r_state)
        ST_FETCH: begin
          if (bus.redirect) begin
            r_pc <= bus.redirect_pc;
          end else if (w_can_issue) begin
            r_state <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (w_ack_accept) begin
            r_pc <= w_pc_plus2;
            if (w_is_hlt) begin
              r_state  <= ST_HALTED;
              r_halted <= 1'b1;
            end else begin
              r_state <= ST_FETCH;
            end
          end else if (w_ack_discard) begin
            // Stale data from a read the PC has already moved past.
            r_kill  <= 1'b0;
            r_state <= ST_FETCH;
            if (bus.redirect) begin
              r_pc <= bus.redirect_pc;
            end
          end else if (bus.redirect) begin
            // Read still in flight: remember to drop its ack.
            r_kill <= 1'b1;
            r_pc   <= bus.redirect_pc;
          end
        end

        ST_HALTED: begin
          // A redirect here cancels an HLT fetched down a taken branch's shadow.
          if (bus.redirect) begin
            r_pc     <= bus.redirect_pc;
            r_state  <= ST_FETCH;
            r_halted <= 1'b0;
          end
        end

        default: begin
          r_state <= ST_FETCH;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] r_perf_wait;
  logic [15:0] r_perf_kill;

  // Saturating counters of cycles spent waiting on memory and of dropped acks.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_perf_wait <= '0;
      r_perf_kill <= '0;
    end else begin
      if ((r_state == ST_WAIT) && (r_perf_wait != 16'hFFFF)) begin
        r_perf_wait <= r_perf_wait + 16'd1;
      end
      if (w_ack_discard && (r_perf_kill != 16'hFFFF)) begin
        r_perf_kill <= r_perf_kill + 16'd1;
      end
    end
  end

  assign perf_wait_cycles = r_perf_wait;
  assign perf_kill_count  = r_perf_kill;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit. A memory model answers each request
// after a programmable latency; expected fetch addresses and expected decode
// deliveries are queued by the stimulus and checked by an independent monitor.
// Inputs change on the falling edge; everything is sampled 2 time units later.
module tb_instr_fetch_unit;

  logic clk;
  logic rst_n;

  instr_fetch_unit_if #(.ADDR_W(16), .DATA_W(16)) bus ();

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] perf_wait_cycles;
  logic [15:0] perf_kill_count;
`endif

  instr_fetch_unit #(
    .ADDR_W   (16),
    .DATA_W   (16),
    .RESET_PC (16'h0000)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .bus              (bus)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_wait_cycles (perf_wait_cycles),
    .perf_kill_count  (perf_kill_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Hand-written instruction memory image.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0000: return 16'h0123;
      16'h0002: return 16'h1456;
      16'h0004: return 16'h2222;
      16'h0006: return 16'hF000;
      16'h0010: return 16'h3010;
      16'h0040: return 16'h4040;
      16'hFFFE: return 16'h5FFE;
      default:  return 16'h0BAD;
    endcase
  endfunction

  // Scoreboard queues
  typedef struct {
    logic [15:0] instr;
    logic [15:0] pc;
    logic [15:0] pc2;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] addr_q[$];

  task automatic push_instr(input logic [15:0] i, input logic [15:0] pc, input logic [15:0] pc2);
    exp_t e;
    e.instr = i;
    e.pc    = pc;
    e.pc2   = pc2;
    exp_q.push_back(e);
  endtask

  // Memory model: one ack mem_lat cycles after each sampled request.
  int          mem_lat = 1;
  logic        m_pend  = 1'b0;
  int          m_cnt   = 0;
  logic [15:0] m_addr  = '0;

  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      if (m_pend) begin
        if (m_cnt <= 1) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = mem_word(m_addr);
          m_pend        = 1'b0;
        end else begin
          m_cnt--;
        end
      end
      #2;
      if (rst_n && bus.mem_req) begin
        m_pend = 1'b1;
        m_cnt  = mem_lat;
        m_addr = bus.mem_addr;
      end
    end
  end

  // Monitor: every request address and every delivery to decode is popped
  // from the scoreboard and compared.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst_n) begin
        if (bus.mem_req) begin
          if (addr_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_req: got mem_addr %h, expected no request (t=%0t)",
                     bus.mem_addr, $time);
          end else begin
            check("mem_addr", bus.mem_addr, addr_q.pop_front());
          end
        end
        if (bus.instr_valid && !bus.stall) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_instr: got %h at %h, expected none (t=%0t)",
                     bus.instr, bus.instr_pc, $time);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("instr", bus.instr, e.instr);
            check("instr_pc", bus.instr_pc, e.pc);
            check("instr_pc_plus2", bus.instr_pc_plus2, e.pc2);
          end
        end
      end
    end
  end

  // One cycle: drive inputs at the falling edge, return at the sample point.
  task automatic step(input logic rst, input logic st, input logic rd,
                      input logic [15:0] rpc, input int lat);
    @(negedge clk);
    rst_n           = rst;
    bus.stall       = st;
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
    mem_lat         = lat;
    #2;
  endtask

  initial begin
    logic [15:0] held_instr;
    logic [15:0] held_pc;

    rst_n           = 1'b0;
    bus.stall       = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;

    // ---- Test 1: reset state and back-to-back fetch with 1-cycle memory ----
    step(0, 0, 0, 16'h0, 1);
    step(0, 0, 0, 16'h0, 1);
    check("rst_instr_valid", 16'(bus.instr_valid), 16'd0);
    check("rst_instr", bus.instr, 16'h0000);
    check("rst_instr_pc", bus.instr_pc, 16'h0000);
    check("rst_halted", 16'(bus.halted), 16'd0);
    check("rst_mem_addr", bus.mem_addr, 16'h0000);

    addr_q.push_back(16'h0000);
    addr_q.push_back(16'h0002);
    addr_q.push_back(16'h0004);
    push_instr(16'h0123, 16'h0000, 16'h0002);
    push_instr(16'h1456, 16'h0002, 16'h0004);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 16'h0, 1);
      check("t1_mem_req", 16'(bus.mem_req), (i % 2 == 0) ? 16'd1 : 16'd0);
    end
    step(0, 0, 0, 16'h0, 1);
    step(0, 0, 0, 16'h0, 1);

    // ---- Tests 2..6 run as one continuous sequence after this reset ----
    addr_q.push_back(16'h0000);
    addr_q.push_back(16'h0002);
    addr_q.push_back(16'h0004);
    addr_q.push_back(16'h0040);
    addr_q.push_back(16'h0006);
    addr_q.push_back(16'h0010);
    addr_q.push_back(16'hFFFE);
    addr_q.push_back(16'h0000);
    addr_q.push_back(16'h0002);
    addr_q.push_back(16'h0000);
    addr_q.push_back(16'h0002);
    push_instr(16'h0123, 16'h0000, 16'h0002);
    push_instr(16'h1456, 16'h0002, 16'h0004);
    push_instr(16'h4040, 16'h0040, 16'h0042);
    push_instr(16'hF000, 16'h0006, 16'h0008);
    push_instr(16'h3010, 16'h0010, 16'h0012);
    push_instr(16'h5FFE, 16'hFFFE, 16'h0000);
    push_instr(16'h0123, 16'h0000, 16'h0002);
    push_instr(16'h0123, 16'h0000, 16'h0002);

    // Test 2: stall for 3 cycles while 0x0123 is buffered
    step(1, 0, 0, 16'h0, 1);                     // c0 request 0x0000
    step(1, 0, 0, 16'h0, 1);                     // c1 ack
    step(1, 1, 0, 16'h0, 1);                     // c2 valid, stalled
    check("t2_valid", 16'(bus.instr_valid), 16'd1);
    check("t2_instr", bus.instr, 16'h0123);
    held_instr = bus.instr;
    held_pc    = bus.instr_pc;
    check("t2_req_stalled", 16'(bus.mem_req), 16'd0);
    for (int i = 0; i < 2; i++) begin            // c3, c4
      step(1, 1, 0, 16'h0, 1);
      check("t2_instr_hold", bus.instr, held_instr);
      check("t2_pc_hold", bus.instr_pc, held_pc);
      check("t2_req_stalled", 16'(bus.mem_req), 16'd0);
    end
    step(1, 0, 0, 16'h0, 1);                     // c5 stall drops
    check("t2_req_resume", 16'(bus.mem_req), 16'd1);
    check("t2_next_addr", bus.mem_addr, 16'h0002);
    step(1, 0, 0, 16'h0, 1);                     // c6 ack 0x1456
    step(1, 0, 0, 16'h0, 3);                     // c7 valid, request 0x0004 (3-cycle)

    // Test 3: redirect while waiting on a slow read
    step(1, 0, 1, 16'h0040, 3);                  // c8 redirect in WAIT
    check("t3_req_in_wait", 16'(bus.mem_req), 16'd0);
    step(1, 0, 0, 16'h0, 3);                     // c9
    check("t3_valid_c9", 16'(bus.instr_valid), 16'd0);
    step(1, 0, 0, 16'h0, 3);                     // c10 stale ack
    check("t3_valid_c10", 16'(bus.instr_valid), 16'd0);
    step(1, 0, 0, 16'h0, 1);                     // c11 refetch
    check("t3_valid_c11", 16'(bus.instr_valid), 16'd0);
    check("t3_req", 16'(bus.mem_req), 16'd1);
    check("t3_addr", bus.mem_addr, 16'h0040);
`ifdef FETCH_PERF_CNT_EN
    check("t3_perf_kill", perf_kill_count, 16'd1);
    check("t3_perf_wait", perf_wait_cycles, 16'd5);
`endif
    step(1, 0, 0, 16'h0, 1);                     // c12 ack 0x4040

    // Test 4: HLT at 0x0006
    step(1, 0, 1, 16'h0006, 1);                  // c13 0x4040 valid, redirect
    check("t4_req_redirect", 16'(bus.mem_req), 16'd0);
    step(1, 0, 0, 16'h0, 1);                     // c14 request 0x0006
    step(1, 0, 0, 16'h0, 1);                     // c15 ack 0xF000
    step(1, 0, 0, 16'h0, 1);                     // c16
    check("t4_valid", 16'(bus.instr_valid), 16'd1);
    check("t4_instr", bus.instr, 16'hF000);
    for (int i = 0; i < 10; i++) begin           // c17..c26
      step(1, 0, 0, 16'h0, 1);
      check("t4_halted", 16'(bus.halted), 16'd1);
      check("t4_no_req", 16'(bus.mem_req), 16'd0);
    end
    check("t4_valid_drained", 16'(bus.instr_valid), 16'd0);

    // Test 5: redirect out of HALTED
    step(1, 0, 1, 16'h0010, 1);
    check("t5_req_redirect", 16'(bus.mem_req), 16'd0);
    step(1, 0, 0, 16'h0, 1);
    check("t5_halted", 16'(bus.halted), 16'd0);
    check("t5_req", 16'(bus.mem_req), 16'd1);
    check("t5_addr", bus.mem_addr, 16'h0010);
    step(1, 0, 0, 16'h0, 1);                     // ack 0x3010

    // Test 6: PC wrap at 0xFFFE, then reset during a slow read
    step(1, 0, 1, 16'hFFFE, 1);                  // 0x3010 valid, redirect
    step(1, 0, 0, 16'h0, 1);                     // request 0xFFFE
    step(1, 0, 0, 16'h0, 1);                     // ack 0x5FFE
    step(1, 0, 0, 16'h0, 1);                     // valid, request wraps to 0
    check("t6_wrap_pc", bus.instr_pc, 16'hFFFE);
    check("t6_wrap_addr", bus.mem_addr, 16'h0000);
    step(1, 0, 0, 16'h0, 1);                     // ack 0x0123
    step(1, 0, 0, 16'h0, 3);                     // valid, request 0x0002 (3-cycle)
    step(0, 0, 0, 16'h0, 3);                     // reset while waiting
    step(0, 0, 0, 16'h0, 3);
    step(1, 0, 0, 16'h0, 1);                     // late ack arrives in FETCH
    check("t6_rst_valid", 16'(bus.instr_valid), 16'd0);
    check("t6_rst_addr", bus.mem_addr, 16'h0000);
    check("t6_rst_req", 16'(bus.mem_req), 16'd1);
    step(1, 0, 0, 16'h0, 1);                     // ack for the new fetch
    check("t6_late_ack_ignored", 16'(bus.instr_valid), 16'd0);
    step(1, 0, 0, 16'h0, 1);                     // valid 0x0123, request 0x0002
    check("t6_refetch_valid", 16'(bus.instr_valid), 16'd1);

    step(0, 0, 0, 16'h0, 1);
    step(0, 0, 0, 16'h0, 1);
    check("addr_q_drained", 16'(addr_q.size()), 16'd0);
    check("exp_q_drained", 16'(exp_q.size()), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
